mem_responder: RTL and testbench

Memory-side responder for the multi-cycle CPU controller's memory port. It accepts one read or write request at a time over a req/ack handshake and services it from an on-chip word RAM after a programmable number of wait states. A small memory-mapped I/O window at the top of the address space backs the controller's IN and OUT instructions. The block sits between the controller and the RAM macro, replacing the direct address/data/wren/q wiring.

---
 rtl/mem_resp_pkg.sv | 9 +
 rtl/mem_resp_ram.sv | 18 +
 rtl/mem_responder.sv | 95 +++++++++
 tb/tb_mem_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared FSM states, I/O window offsets and status bit positions
package mem_resp_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam int IO_IN = 0;
  localparam int IO_STAT = 1;
  localparam int IO_OUT = 2;
  localparam int STAT_FULL = 0;
  localparam int STAT_OVR = 1;
endpackage

// File: rtl/mem_resp_ram.sv
// mem_resp_ram: single-port word RAM, synchronous read and write, no reset
module mem_resp_ram #(
  parameter int DEPTH = 4096,
  parameter int DATA_W = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    q <= mem[addr];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: req/ack memory responder with wait states, RAM and a small I/O window
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH = 4096,
  parameter int WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] IO_BASE = 'hFF00
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid
);
  localparam int AW = $clog2(DEPTH);
  state_t state, state_nx;
  logic we_q;
  logic [ADDR_W-1:0] addr_q, off;
  logic [DATA_W-1:0] wdata_q, q, hold, stat, rd_nx;
  logic [3:0] cnt;
  logic in_full, overrun, commit, is_ram, is_io, a_in, a_stat, a_out, mapped;
  logic [AW-1:0] ram_addr;
  assign commit = state == ACCESS && cnt == '0;
  assign is_ram = addr_q < ADDR_W'(DEPTH);
  assign is_io = addr_q >= IO_BASE;
  assign off = addr_q - IO_BASE;
  assign a_in = is_io && off == ADDR_W'(IO_IN) && !we_q;
  assign a_stat = is_io && off == ADDR_W'(IO_STAT) && !we_q;
  assign a_out = is_io && off == ADDR_W'(IO_OUT);
  assign mapped = is_ram || a_in || a_stat || a_out;
  // RAM address follows the live request in IDLE so q is ready one edge after acceptance
  assign ram_addr = state == IDLE ? addr[AW-1:0] : addr_q[AW-1:0];
  mem_resp_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_ram (
    .clock(clock),
    .addr(ram_addr),
    .wdata(wdata_q),
    .we(commit && is_ram && we_q),
    .q(q)
  );
  always_comb begin
    stat = '0;
    stat[STAT_FULL] = in_full;
    stat[STAT_OVR] = overrun;
    rd_nx = !mapped ? '0 : we_q ? rdata : a_in ? hold : a_stat ? stat : a_out ? out_port : q;
    state_nx = state == IDLE ? (req ? ACCESS : IDLE) : state == ACCESS ? (cnt == '0 ? RESP : ACCESS) : IDLE;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cnt <= '0;
      ack <= 1'b0;
      rdata <= '0;
      err <= 1'b0;
      out_port <= '0;
      out_valid <= 1'b0;
      hold <= '0;
      in_full <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        we_q <= we;
        addr_q <= addr;
        wdata_q <= wdata;
        cnt <= 4'(WAIT_CYCLES);
      end else if (state == ACCESS && cnt != '0) cnt <= cnt - 4'd1;
      ack <= commit;
      out_valid <= commit && a_out && we_q;
      if (commit) begin
        err <= !mapped;
        rdata <= rd_nx;
      end
      if (commit && a_out && we_q) out_port <= wdata_q;
      if (in_valid) hold <= in_data;
      // a capture on the same edge as a drain wins, keeping the fresh word visible
      in_full <= in_valid || (in_full && !(commit && a_in));
      overrun <= (in_valid && in_full) || (overrun && !(commit && a_stat));
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized check of two responders (0 and 3 wait states) against a transaction-level model
module tb_mem_responder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req [2], we [2], in_valid [2];
  logic [15:0] addr [2], wdata [2], in_data [2];
  logic ack [2], err [2], out_valid [2];
  logic [15:0] rdata [2], out_port [2];
  int total = 0, bad = 0, cyc = 0;
  bit rnd_on = 0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_responder #(.WAIT_CYCLES(g * 3)) dut (
      .clock(clk), .reset_n(rst_n), .req(req[g]), .we(we[g]), .addr(addr[g]), .wdata(wdata[g]),
      .ack(ack[g]), .rdata(rdata[g]), .err(err[g]), .in_data(in_data[g]), .in_valid(in_valid[g]),
      .out_port(out_port[g]), .out_valid(out_valid[g])
    );
  end

  // model: a request accepted at edge E0 commits at edge E0+1+wait, next acceptance two edges later
  int ack_edge [2];
  logic p_we [2];
  logic [15:0] p_addr [2], p_wdata [2];
  logic [15:0] m_mem [2][4096];
  logic [15:0] m_hold [2], m_out [2], m_rdata [2];
  logic m_full [2], m_ovr [2], m_err [2], m_ack [2], m_ov [2];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        ack_edge[i] = -100; m_hold[i] = 0; m_out[i] = 0; m_rdata[i] = 0;
        m_full[i] = 0; m_ovr[i] = 0; m_err[i] = 0; m_ack[i] = 0; m_ov[i] = 0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        logic full_old;
        logic [15:0] a;
        full_old = m_full[i];
        a = p_addr[i];
        m_ack[i] = 0;
        m_ov[i] = 0;
        if (ack_edge[i] == cyc) begin
          m_ack[i] = 1;
          m_err[i] = 0;
          if (a < 16'd4096) begin
            if (p_we[i]) m_mem[i][a[11:0]] = p_wdata[i];
            else m_rdata[i] = m_mem[i][a[11:0]];
          end else if (a == 16'hFF00 && !p_we[i]) begin
            m_rdata[i] = m_hold[i]; m_full[i] = 0;
          end else if (a == 16'hFF01 && !p_we[i]) begin
            m_rdata[i] = {14'd0, m_ovr[i], m_full[i]}; m_ovr[i] = 0;
          end else if (a == 16'hFF02) begin
            if (p_we[i]) begin m_out[i] = p_wdata[i]; m_ov[i] = 1; end
            else m_rdata[i] = m_out[i];
          end else begin
            m_err[i] = 1; m_rdata[i] = 0;
          end
        end else if (req[i] && cyc >= ack_edge[i] + 2) begin
          ack_edge[i] = cyc + 1 + i * 3;
          p_we[i] = we[i]; p_addr[i] = addr[i]; p_wdata[i] = wdata[i];
        end
        if (in_valid[i]) begin
          if (full_old) m_ovr[i] = 1;
          m_hold[i] = in_data[i];
          m_full[i] = 1;
        end
      end
    end
  end

  task automatic chk(input string n, input int i, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d t=%0t got=%h want=%h", n, i, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("ack", i, 16'(ack[i]), 16'(m_ack[i]));
      chk("out_valid", i, 16'(out_valid[i]), 16'(m_ov[i]));
      chk("out_port", i, out_port[i], m_out[i]);
      chk("rdata", i, rdata[i], m_rdata[i]);
      if (m_ack[i]) chk("err", i, 16'(err[i]), 16'(m_err[i]));
    end
  end

  task automatic xact(input int i, input logic w, input logic [15:0] a, input logic [15:0] d,
                      output int lat, output logic [15:0] rd, output logic er, output logic ov, output logic [15:0] op);
    @(negedge clk);
    req[i] = 1; we[i] = w; addr[i] = a; wdata[i] = d;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ack[i]) begin lat = n - 1; break; end
    end
    rd = rdata[i]; er = err[i]; ov = out_valid[i]; op = out_port[i];
    req[i] = 0;
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL ack_timeout inst=%0d addr=%h", i, a);
    end
  endtask

  task automatic pulse_in(input int i, input logic [15:0] d);
    @(negedge clk);
    in_valid[i] = 1; in_data[i] = d;
    @(negedge clk);
    in_valid[i] = 0;
  endtask

  task automatic rnd_drv(input int i);
    logic [15:0] unm [5] = '{16'h1000, 16'h2000, 16'hFEFF, 16'hFF03, 16'hFFFF};
    logic [15:0] a, d, rd, op;
    logic w, er, ov;
    int r, idx, lat;
    for (int k = 0; k < 150; k++) begin
      r = $urandom % 9;
      w = 1'($urandom);
      d = 16'($urandom);
      idx = $urandom % 17;
      a = idx == 16 ? 16'd4095 : 16'(idx);
      if (r == 5) begin a = 16'hFF00; w = 0; end
      else if (r == 6) begin a = 16'hFF01; w = 0; end
      else if (r == 7) a = 16'hFF02;
      else if (r == 8) a = unm[$urandom % 5];
      xact(i, w, a, d, lat, rd, er, ov, op);
      chk("rnd_latency", i, 16'(lat), 16'(1 + i * 3));
      repeat ($urandom % 3) @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] rd, op, v9, d;
    logic er, ov;
    int lat;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; we[i] = 0; addr[i] = 0; wdata[i] = 0; in_valid[i] = 0; in_data[i] = 0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ack", i, 16'(ack[i]), 16'h0);
      chk("rst_rdata", i, rdata[i], 16'h0);
      chk("rst_err", i, 16'(err[i]), 16'h0);
      chk("rst_out_port", i, out_port[i], 16'h0);
      chk("rst_out_valid", i, 16'(out_valid[i]), 16'h0);
    end
    #2 rst_n = 1;
    xact(0, 1, 16'd5, 16'h1234, lat, rd, er, ov, op);
    chk("w0_write_lat", 0, 16'(lat), 16'd1);
    xact(0, 0, 16'd5, 16'h0, lat, rd, er, ov, op);
    chk("w0_read_lat", 0, 16'(lat), 16'd1);
    chk("w0_read_data", 0, rd, 16'h1234);
    chk("w0_read_err", 0, 16'(er), 16'h0);
    v9 = 0;
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 17; a++) begin
        d = 16'($urandom);
        if (i == 1 && a == 9) v9 = d;
        xact(i, 1, a == 16 ? 16'd4095 : 16'(a), d, lat, rd, er, ov, op);
      end
    xact(1, 0, 16'd0, 16'h0, lat, rd, er, ov, op);
    chk("w3_read_lat", 1, 16'(lat), 16'd4);
    @(negedge clk);
    chk("w3_ack_one_cycle", 1, 16'(ack[1]), 16'h0);
    xact(0, 1, 16'hFF02, 16'h00AB, lat, rd, er, ov, op);
    chk("out_port_ab", 0, op, 16'h00AB);
    chk("out_valid_with_ack", 0, 16'(ov), 16'h1);
    pulse_in(0, 16'h0007);
    pulse_in(0, 16'h0008);
    xact(0, 0, 16'hFF01, 16'h0, lat, rd, er, ov, op);
    chk("stat_full_ovr", 0, rd, 16'h0003);
    xact(0, 0, 16'hFF00, 16'h0, lat, rd, er, ov, op);
    chk("in_word", 0, rd, 16'h0008);
    xact(0, 0, 16'hFF01, 16'h0, lat, rd, er, ov, op);
    chk("stat_cleared", 0, rd, 16'h0000);
    xact(1, 0, 16'h2000, 16'h0, lat, rd, er, ov, op);
    chk("unmapped_2000_err", 1, 16'(er), 16'h1);
    chk("unmapped_2000_rdata", 1, rd, 16'h0);
    xact(1, 0, 16'hFF05, 16'h0, lat, rd, er, ov, op);
    chk("unmapped_ff05_err", 1, 16'(er), 16'h1);
    chk("unmapped_ff05_rdata", 1, rd, 16'h0);
    @(negedge clk);
    req[1] = 1; we[1] = 1; addr[1] = 16'd9; wdata[1] = ~v9;
    repeat (2) @(negedge clk);
    #2 rst_n = 0; req[1] = 0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("abort_ack", i, 16'(ack[i]), 16'h0);
      chk("abort_rdata", i, rdata[i], 16'h0);
      chk("abort_err", i, 16'(err[i]), 16'h0);
      chk("abort_out_port", i, out_port[i], 16'h0);
      chk("abort_out_valid", i, 16'(out_valid[i]), 16'h0);
    end
    @(negedge clk);
    #2 rst_n = 1;
    xact(1, 0, 16'd9, 16'h0, lat, rd, er, ov, op);
    chk("aborted_write_absent", 1, rd, v9);
    rnd_on = 1;
    fork
      begin
        fork
          rnd_drv(0);
          rnd_drv(1);
        join
        rnd_on = 0;
      end
      while (rnd_on) begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          in_valid[i] = ($urandom % 6) == 0;
          in_data[i] = 16'($urandom);
        end
      end
    join
    for (int i = 0; i < 2; i++) in_valid[i] = 0;
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
